file_stream_tx: RTL and testbench

Transmit-side partner to the file-size receive counter in the data control router. On start, it reads a file of `filesize` words from a word-addressed memory, beginning at `base_addr`. It streams the words downstream over a valid/ready interface, flags the last word, and reports completion on `done`. Downstream backpressure (`out_ready` low) is the transmit-side counterpart of the receiver's pause.

---
 rtl/file_stream_pkg.sv | 20 ++
 rtl/stream_skid_fifo.sv | 49 ++++
 rtl/file_stream_tx.sv | 145 ++++++++++++++
 tb/tb_file_stream_tx.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/file_stream_pkg.sv
// Shared types for the file transmit path: FSM encoding, width defaults and
// the output buffer entry that carries a word together with its last flag.
package file_stream_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int ADDR_W_DEF     = 32;
    localparam int FIFO_DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic                  last;
        logic [DATA_W_DEF-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry output buffer; push and pop may coincide at any occupancy, and
// storage is cleared on reset so the head reads as zero afterwards.
module stream_skid_fifo
    import file_stream_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  fifo_entry_t push_entry,
    input  logic        pop,
    output fifo_entry_t head,
    output logic [1:0]  count
);

    fifo_entry_t mem_q [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;
    logic        do_pop;
    logic        do_push;

    assign do_pop  = pop && (count_q != 2'd0);
    // When full, a push is only legal if the head leaves in the same cycle.
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/file_stream_tx.sv
// Reads filesize words from memory starting at base_addr and streams them
// over valid/ready, tagging the final word and signalling completion on done.
module file_stream_tx
    import file_stream_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] filesize,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output state_e            dbg_state
);

    // Valid/ready: a word transfers on every rising edge where out_valid and
    // out_ready are both high; while out_valid is high and out_ready low the
    // word and its last flag hold steady, and out_valid never drops unaccepted.

    state_e            state_q;
    logic [ADDR_W-1:0] filesize_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] rd_idx_q;
    logic [ADDR_W-1:0] tx_idx_q;
    logic              inflight_q;
    logic              rd_last_q;
    logic              last_acc_q;
    logic              busy_q;
    logic              done_q;

    fifo_entry_t       push_entry;
    fifo_entry_t       head;
    logic [1:0]        fifo_count;
    logic              pop;
    logic              rd_en;
    logic [2:0]        occupancy;
    logic [2:0]        credit_lim;

    assign pop        = out_valid && out_ready;
    // Count the word already in flight so a returning read always has room.
    assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign credit_lim = 3'(FIFO_DEPTH) + {2'b00, pop};
    assign rd_en      = (state_q == ST_RUN) && (rd_idx_q != filesize_q) &&
                        (occupancy < credit_lim);

    always_comb begin
        push_entry      = '0;
        push_entry.last = rd_last_q;
        push_entry.data = mem_rd_data;
    end

    stream_skid_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight_q),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            filesize_q <= '0;
            base_q     <= '0;
            rd_idx_q   <= '0;
            tx_idx_q   <= '0;
            inflight_q <= 1'b0;
            rd_last_q  <= 1'b0;
            last_acc_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
        end else begin
            inflight_q <= rd_en;
            rd_last_q  <= rd_en && (rd_idx_q == filesize_q - 1'b1);
            if (rd_en) begin
                rd_idx_q <= rd_idx_q + 1'b1;
            end
            if (pop) begin
                tx_idx_q <= tx_idx_q + 1'b1;
            end
            if (pop && out_last) begin
                last_acc_q <= 1'b1;
                busy_q     <= 1'b0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        filesize_q <= filesize;
                        base_q     <= base_addr;
                        rd_idx_q   <= '0;
                        tx_idx_q   <= '0;
                        last_acc_q <= 1'b0;
                        if (filesize != '0) begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (rd_idx_q == filesize_q) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (last_acc_q) begin
                        state_q    <= ST_IDLE;
                        last_acc_q <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always @(posedge clk) begin
        if (!rst && pop) begin
            assert (out_last == (tx_idx_q == filesize_q - 1'b1));
        end
    end

    assign mem_rd_en = rd_en;
    assign mem_addr  = base_q + rd_idx_q;
    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = head.data;
    assign out_last  = out_valid && head.last;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_file_stream_tx.sv
// Bench for file_stream_tx: memory model, scoreboard queues of expected words
// and read addresses, and one task per scenario.
module tb_file_stream_tx;
    import file_stream_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] filesize;
    logic [31:0] base_addr;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rd_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        done;
    state_e      dbg_state;

    int total = 0;
    int bad   = 0;

    logic [32:0] exp_q[$];
    logic [31:0] addr_q[$];

    logic        mon_en = 1'b0;
    int          hs_cnt = 0;
    int          occ_m = 0;
    logic        prev_rd = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    logic        mon_hs;
    logic [32:0] mon_e;
    logic [31:0] mon_a;

    file_stream_tx dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .filesize    (filesize),
        .base_addr   (base_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory returns data one cycle after the strobe; garbage otherwise.
    always @(posedge clk) begin
        mem_rd_data <= mem_rd_en ? mem_f(mem_addr) : $urandom();
    end

    always @(negedge clk) begin
        if (rst) begin
            occ_m      = 0;
            prev_rd    = 1'b0;
            prev_stall = 1'b0;
        end else if (mon_en) begin
            mon_hs = out_valid && out_ready;
            if (prev_stall) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             out_valid, out_data, out_last, prev_data, prev_last);
                end
            end
            if (mon_hs) begin
                total++;
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_word: got d=%h l=%b want none", out_data, out_last);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({out_last, out_data} !== mon_e) begin
                        bad++;
                        $display("FAIL word: got l=%b d=%h want l=%b d=%h",
                                 out_last, out_data, mon_e[32], mon_e[31:0]);
                    end
                end
            end
            if (mem_rd_en) begin
                total++;
                if (addr_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_read: got addr=%h want no read", mem_addr);
                end else begin
                    mon_a = addr_q.pop_front();
                    if (mem_addr !== mon_a) begin
                        bad++;
                        $display("FAIL read_addr: got %h want %h", mem_addr, mon_a);
                    end
                end
            end
            occ_m = occ_m + int'(prev_rd) - int'(mon_hs);
            if (prev_rd || mon_hs) begin
                total++;
                if (occ_m > 2 || occ_m < 0) begin
                    bad++;
                    $display("FAIL occupancy: got %0d want 0..2", occ_m);
                end
            end
            prev_rd    = mem_rd_en;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic run_file(input logic [31:0] fs, input logic [31:0] base, input int mode,
                            input bit glitch, output int done_low, output int first_valid,
                            output int busy_rises);
        int   cyc;
        logic prev_busy;
        for (int i = 0; i < int'(fs); i++) begin
            exp_q.push_back({(i == int'(fs) - 1), mem_f(base + 32'(i))});
            addr_q.push_back(base + 32'(i));
        end
        @(posedge clk); #1;
        start = 1'b1; filesize = fs; base_addr = base; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; done_low = 0; first_valid = -1; busy_rises = 0; prev_busy = 1'b0;
        while ((exp_q.size() != 0 || done !== 1'b1) && cyc < 300) begin
            out_ready = (mode == 0) || (cyc % 3 == 0);
            if (glitch && cyc == 2) begin
                start = 1'b1; filesize = 32'd7; base_addr = 32'h9000;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (done !== 1'b1) done_low++;
            if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
            if (busy === 1'b1 && !prev_busy) busy_rises++;
            prev_busy = busy;
            @(posedge clk); #1;
        end
        start = 1'b0; out_ready = 1'b1;
        total++;
        if (cyc >= 300) begin
            bad++;
            $display("FAIL file_timeout: got %0d words left want 0 within 300 cycles", exp_q.size());
        end
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0 || addr_q.size() != 0 || busy !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL file_end: got words=%0d reads=%0d busy=%b done=%b want 0 0 0 1",
                     exp_q.size(), addr_q.size(), busy, done);
        end
        exp_q.delete();
        addr_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++;
        if (mem_rd_en !== 1'b0 || mem_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_mem: got en=%b addr=%h want 0 0", mem_rd_en, mem_addr);
        end
        total++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: got v=%b d=%h l=%b want 0 0 0", out_valid, out_data, out_last);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL reset_status: got busy=%b done=%b want 0 1", busy, done);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int dl, fv, br;
        run_file(32'd4, 32'h100, 0, 1'b0, dl, fv, br);
        total++;
        if (dl != 7) begin
            bad++;
            $display("FAIL basic_done_low: got %0d want 7", dl);
        end
        total++;
        if (fv != 3) begin
            bad++;
            $display("FAIL basic_first_valid: got %0d want 3", fv);
        end
        total++;
        if (br != 1) begin
            bad++;
            $display("FAIL basic_busy_periods: got %0d want 1", br);
        end
    endtask

    task automatic test_zero();
        @(posedge clk); #1;
        start = 1'b1; filesize = 32'd0; base_addr = 32'h500;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || done !== 1'b1 || mem_rd_en !== 1'b0 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL zero_file: got busy=%b done=%b rd=%b v=%b want 0 1 0 0",
                         busy, done, mem_rd_en, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int dl, fv, br;
        run_file(32'd8, 32'h400, 1, 1'b0, dl, fv, br);
        total++;
        if (br != 1) begin
            bad++;
            $display("FAIL bp_busy_periods: got %0d want 1", br);
        end
    endtask

    task automatic test_wrap();
        int dl, fv, br;
        run_file(32'd4, 32'hFFFF_FFFE, 0, 1'b0, dl, fv, br);
        total++;
        if (dl != 7) begin
            bad++;
            $display("FAIL wrap_done_low: got %0d want 7", dl);
        end
    endtask

    task automatic test_reset_mid();
        int n, dl, fv, br;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({(i == 9), mem_f(32'h2000 + 32'(i))});
            addr_q.push_back(32'h2000 + 32'(i));
        end
        hs_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; filesize = 32'd10; base_addr = 32'h2000; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (hs_cnt < 3 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (hs_cnt < 3) begin
            bad++;
            $display("FAIL mid_wait: got %0d words want 3 within 50 cycles", hs_cnt);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({mem_rd_en, mem_addr, out_valid, out_data, out_last, busy, done} !==
            {1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL mid_reset_outputs: got rd=%b a=%h v=%b d=%h l=%b b=%b dn=%b want 0 0 0 0 0 0 1",
                     mem_rd_en, mem_addr, out_valid, out_data, out_last, busy, done);
        end
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || mem_rd_en !== 1'b0) begin
                bad++;
                $display("FAIL mid_stale: got v=%b rd=%b want 0 0", out_valid, mem_rd_en);
            end
        end
        run_file(32'd2, 32'h3000, 0, 1'b0, dl, fv, br);
        total++;
        if (dl != 5) begin
            bad++;
            $display("FAIL mid_refile_done_low: got %0d want 5", dl);
        end
    endtask

    task automatic test_start_during_run();
        int dl, fv, br;
        run_file(32'd5, 32'h800, 0, 1'b1, dl, fv, br);
        total++;
        if (br != 1) begin
            bad++;
            $display("FAIL restart_busy_periods: got %0d want 1", br);
        end
        total++;
        if (dl != 8) begin
            bad++;
            $display("FAIL restart_done_low: got %0d want 8", dl);
        end
    endtask

    initial begin
        start = 1'b0;
        filesize = '0;
        base_addr = '0;
        out_ready = 1'b1;
        test_reset();
        mon_en = 1'b1;
        test_basic();
        test_zero();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_start_during_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
